// File: rtl/cond_unit_ckpt.sv
// Execute-stage condition unit: ARM condition decode, NZCV flags with grouped write enables,
// and a DEPTH-entry flag checkpoint FIFO for mispredict rollback. Optional: COND_CKPT_ERR_EN.
module cond_unit_ckpt #(
  parameter int NGROUPS = 2,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NGROUPS-1:0]           FlagWriteE,
  input  logic [3:0]                   CondE,
  input  logic [3:0]                   FlagsE,
  input  logic [3:0]                   ALUFlags,
  input  logic                         CkptPush,
  input  logic                         CkptCommit,
  input  logic                         CkptRestore,
  output logic [3:0]                   Flags,
  output logic                         CondExE,
  output logic [$clog2(DEPTH+1)-1:0]   CkptCount,
  output logic                         CkptFull,
  output logic                         CkptEmpty,
  output logic                         CkptErr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int GW = 4 / NGROUPS;

  logic [3:0]    r_flags;
  logic [3:0]    r_mem [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;

  logic       w_n, w_z, w_c, w_v, w_cond;
  logic [3:0] w_bit_we, w_flags_next;
  logic       w_empty, w_full, w_restore, w_commit, w_push;

  assign {w_n, w_z, w_c, w_v} = FlagsE;

  always_comb begin
    w_cond = 1'b1;
    case (CondE)
      4'd0:  w_cond = w_z;
      4'd1:  w_cond = !w_z;
      4'd2:  w_cond = w_c;
      4'd3:  w_cond = !w_c;
      4'd4:  w_cond = w_n;
      4'd5:  w_cond = !w_n;
      4'd6:  w_cond = w_v;
      4'd7:  w_cond = !w_v;
      4'd8:  w_cond = w_c & !w_z;
      4'd9:  w_cond = !w_c | w_z;
      4'd10: w_cond = (w_n == w_v);
      4'd11: w_cond = (w_n != w_v);
      4'd12: w_cond = !w_z & (w_n == w_v);
      4'd13: w_cond = w_z | (w_n != w_v);
      default: w_cond = 1'b1;
    endcase
  end
  assign CondExE = w_cond;

  genvar g;
  generate
    for (g = 0; g < NGROUPS; g++) begin : g_grp
      assign w_bit_we[g*GW +: GW] = {GW{FlagWriteE[g] & w_cond}};
    end
  endgenerate

  assign w_flags_next = (ALUFlags & w_bit_we) | (r_flags & ~w_bit_we);

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  // A restore on an empty FIFO is a no-op, so only a valid restore suppresses other ops.
  assign w_restore = CkptRestore & !w_empty;
  assign w_commit  = !w_restore & CkptCommit & !w_empty;
  assign w_push    = !w_restore & CkptPush & (!w_full | w_commit);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_restore) begin
      r_flags <= r_mem[r_head];
      r_count <= '0;
      r_head  <= r_tail;
    end else begin
      r_flags <= w_flags_next;
      if (w_push)   r_tail <= r_tail + 1'b1;
      if (w_commit) r_head <= r_head + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_commit);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_flags_next;
  end

`ifdef COND_CKPT_ERR_EN
  logic r_err;
  logic w_err;
  assign w_err = (CkptRestore & w_empty)
               | (!w_restore & CkptCommit & w_empty)
               | (!w_restore & CkptPush & w_full & !w_commit);
  always_ff @(posedge clk) begin
    if (reset)      r_err <= 1'b0;
    else if (w_err) r_err <= 1'b1;
  end
  assign CkptErr = r_err;
`else
  assign CkptErr = 1'b0;
`endif

  assign Flags     = r_flags;
  assign CkptCount = r_count;
  assign CkptFull  = w_full;
  assign CkptEmpty = w_empty;
endmodule

// File: tb/tb_cond_unit_ckpt.sv
// Directed + random bench for cond_unit_ckpt against a queue-based flag/checkpoint model.
module tb_cond_unit_ckpt;
  localparam int NGROUPS = 2;
  localparam int DEPTH   = 4;
  localparam int CW      = $clog2(DEPTH+1);
`ifdef COND_CKPT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [NGROUPS-1:0] FlagWriteE;
  logic [3:0] CondE, FlagsE, ALUFlags;
  logic CkptPush, CkptCommit, CkptRestore;
  logic [3:0] Flags;
  logic CondExE;
  logic [CW-1:0] CkptCount;
  logic CkptFull, CkptEmpty, CkptErr;

  always #5 clk = ~clk;

  cond_unit_ckpt #(.NGROUPS(NGROUPS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .FlagWriteE(FlagWriteE), .CondE(CondE), .FlagsE(FlagsE),
    .ALUFlags(ALUFlags), .CkptPush(CkptPush), .CkptCommit(CkptCommit), .CkptRestore(CkptRestore),
    .Flags(Flags), .CondExE(CondExE), .CkptCount(CkptCount), .CkptFull(CkptFull),
    .CkptEmpty(CkptEmpty), .CkptErr(CkptErr)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: architectural flags, checkpoint queue (front = oldest), sticky error.
  logic [3:0] m_flags;
  logic [3:0] m_q[$];
  bit         m_err;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_ref(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic model_step(input bit rst);
    logic [3:0] fn;
    bit pass;
    if (rst) begin
      m_flags = '0; m_q.delete(); m_err = 0;
      return;
    end
    pass = cond_ref(CondE, FlagsE);
    fn = m_flags;
    for (int b = 0; b < 4; b++)
      if (pass && FlagWriteE[b / (4 / NGROUPS)]) fn[b] = ALUFlags[b];
    if (CkptRestore && m_q.size() > 0) begin
      m_flags = m_q[0];
      m_q.delete();
    end else begin
      if (CkptRestore) m_err = 1;
      if (CkptCommit) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1;
      end
      if (CkptPush) begin
        if (m_q.size() < DEPTH) m_q.push_back(fn);
        else m_err = 1;
      end
      m_flags = fn;
    end
  endtask

  task automatic cyc(input bit rst, input logic [NGROUPS-1:0] fwe, input logic [3:0] cond,
                     input logic [3:0] fe, input logic [3:0] alu,
                     input bit push, input bit commit, input bit restore);
    @(negedge clk);
    reset = rst; FlagWriteE = fwe; CondE = cond; FlagsE = fe; ALUFlags = alu;
    CkptPush = push; CkptCommit = commit; CkptRestore = restore;
    #1;
    check("condexe", {7'd0, CondExE}, {7'd0, cond_ref(cond, fe)});
    model_step(rst);
    @(posedge clk);
    #1;
    check("flags", {4'd0, Flags}, {4'd0, m_flags});
    check("count", 8'(CkptCount), 8'(m_q.size()));
    check("full",  {7'd0, CkptFull},  {7'd0, m_q.size() == DEPTH});
    check("empty", {7'd0, CkptEmpty}, {7'd0, m_q.size() == 0});
    check("err",   {7'd0, CkptErr},   {7'd0, ERR_EN & m_err});
  endtask

  initial begin
    reset = 1; FlagWriteE = '0; CondE = '0; FlagsE = '0; ALUFlags = '0;
    CkptPush = 0; CkptCommit = 0; CkptRestore = 0;
    m_flags = '0; m_err = 0;

    cyc(1, 2'b00, 4'd14, 4'h0, 4'h0, 0, 0, 0);
    check("rst_flags", {4'd0, Flags}, 8'h00);
    check("rst_empty", {7'd0, CkptEmpty}, 8'h01);

    // AL write then failing EQ
    cyc(0, 2'b11, 4'd14, 4'h0, 4'b0100, 0, 0, 0);
    check("al_write", {4'd0, Flags}, 8'h04);
    cyc(0, 2'b11, 4'd0, 4'h0, 4'b1111, 0, 0, 0);
    check("eq_blocked", {4'd0, Flags}, 8'h04);

    // group enables
    cyc(1, 2'b00, 4'd14, 4'h0, 4'h0, 0, 0, 0);
    cyc(0, 2'b10, 4'd14, 4'h0, 4'b1111, 0, 0, 0);
    check("grp_hi", {4'd0, Flags}, 8'h0C);
    cyc(0, 2'b01, 4'd14, 4'h0, 4'b1111, 0, 0, 0);
    check("grp_lo", {4'd0, Flags}, 8'h0F);

    // snapshot captures same-cycle write
    cyc(0, 2'b11, 4'd14, 4'h0, 4'b0010, 0, 0, 0);
    cyc(0, 2'b11, 4'd14, 4'h0, 4'b1000, 1, 0, 0);
    cyc(0, 2'b11, 4'd14, 4'h0, 4'b0001, 0, 0, 0);
    cyc(0, 2'b11, 4'd14, 4'h0, 4'b0001, 0, 0, 0);
    cyc(0, 2'b00, 4'd14, 4'h0, 4'h0, 0, 0, 1);
    check("restore_val", {4'd0, Flags}, 8'h08);
    check("restore_cnt", 8'(CkptCount), 8'h00);

    // fill, overflow, push+commit while full, restore overriding everything
    cyc(0, 2'b11, 4'd14, 4'h0, 4'b0011, 1, 0, 0);
    cyc(0, 2'b11, 4'd14, 4'h0, 4'b0110, 1, 0, 0);
    cyc(0, 2'b11, 4'd14, 4'h0, 4'b1001, 1, 0, 0);
    cyc(0, 2'b11, 4'd14, 4'h0, 4'b1100, 1, 0, 0);
    check("full_set", {7'd0, CkptFull}, 8'h01);
    cyc(0, 2'b11, 4'd14, 4'h0, 4'b0101, 1, 0, 0);
    check("ovf_cnt", 8'(CkptCount), 8'h04);
    check("ovf_err", {7'd0, CkptErr}, {7'd0, ERR_EN});
    cyc(0, 2'b11, 4'd14, 4'h0, 4'b1110, 1, 1, 0);
    check("pc_full_cnt", 8'(CkptCount), 8'h04);
    cyc(0, 2'b11, 4'd14, 4'h0, 4'b1111, 1, 1, 1);
    check("rst_override", {4'd0, Flags}, 8'h06);
    check("rst_ovr_cnt", 8'(CkptCount), 8'h00);

    // empty-FIFO misuse, then reset during a restore
    cyc(1, 2'b00, 4'd14, 4'h0, 4'h0, 0, 0, 0);
    cyc(0, 2'b00, 4'd14, 4'h0, 4'h0, 0, 1, 1);
    check("empty_err", {7'd0, CkptErr}, {7'd0, ERR_EN});
    cyc(0, 2'b11, 4'd14, 4'h0, 4'b1010, 1, 0, 0);
    cyc(1, 2'b11, 4'd14, 4'h0, 4'b0101, 1, 1, 1);
    check("rst_mid_flags", {4'd0, Flags}, 8'h00);
    check("rst_mid_err", {7'd0, CkptErr}, 8'h00);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) == 0,
          NGROUPS'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
          $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cond_unit_ckpt.md
# cond_unit_ckpt

Parametrised successor to the pipeline's condition unit. It evaluates the ARM condition field in Execute and holds the architectural NZCV flags with per-group write enables. It adds a DEPTH-entry FIFO of flag checkpoints, so that speculatively executed flag-setting instructions after a predicted branch can be rolled back on mispredict. It sits in the Execute stage between the ALU flag outputs and the hazard/branch-resolution logic.

## Interface
Parameters:
- NGROUPS, 2, number of independently enabled flag write groups; legal values 1, 2, 4; group g covers Flags bits [(g+1)*4/NGROUPS-1 : g*4/NGROUPS].
- DEPTH, 4, checkpoint FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- FlagWriteE  in  NGROUPS  per-group flag write request from Execute.
- CondE  in  4  condition field of the instruction in Execute.
- FlagsE  in  4  {N,Z,C,V} (bit 3 = N), the flags the condition is evaluated against.
- ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle.
- CkptPush  in  1  snapshot flags (predicted branch enters Execute).
- CkptCommit  in  1  oldest branch resolved correctly; drop oldest checkpoint.
- CkptRestore  in  1  oldest branch mispredicted; roll back flags and flush all checkpoints.
- Flags  out  4  architectural flag register.
- CondExE  out  1  condition passed.
- CkptCount  out  $clog2(DEPTH+1)  occupied entries.
- CkptFull  out  1  CkptCount == DEPTH.
- CkptEmpty  out  1  CkptCount == 0.
- CkptErr  out  1  sticky protocol-error flag.

## Operation
- Condition decode on FlagsE: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 1.
- Group write enable: FlagWE[g] = FlagWriteE[g] & CondExE. Enabled groups load the matching ALUFlags bits; other bits hold.
- FlagsNext is the value Flags takes at the next edge, including this cycle's gated write.
- Push: writes FlagsNext to the tail entry, tail and count increment. Tail and head pointers wrap modulo DEPTH.
- Commit: head and count advance; the entry contents are don't-care afterwards.
- Restore: Flags <= head entry, count <= 0, head <= tail. Restore overrides any same-cycle flag write, push, or commit; those are discarded.
- Push and commit in the same cycle (no restore): both take effect, count is unchanged, and this is legal when full.
- Errors:
  - Push when full without a same-cycle commit: push is dropped.
  - Commit when empty: ignored; a same-cycle push still proceeds.
  - Restore when empty: ignored, and flag writes proceed normally.
  - Each error case sets CkptErr. CkptErr clears only on reset.

## Timing
- CondExE is combinational from CondE and FlagsE, with zero latency.
- Flags, pointers, count, and CkptErr update on the rising edge. A pushed snapshot is visible to a restore from the next cycle.
- Reset (wins over everything, including mid-restore): Flags = 0, count = 0, pointers = 0, CkptEmpty = 1, CkptFull = 0, CkptErr = 0.

## Configuration
- COND_CKPT_ERR_EN:
  - Defined: error detection and sticky CkptErr are compiled in as above.
  - Undefined: CkptErr is tied to 0 and the detection logic is removed. Illegal requests are still ignored identically (drop/ignore behaviour is unchanged).

## Test plan
- Reset, then CondE=14 with FlagWriteE=2'b11 and ALUFlags=4'b0100 -> Flags=4'b0100 next cycle, CondExE=1. Then CondE=0 (EQ) with FlagsE=4'b0000 -> CondExE=0, and a write attempt of ALUFlags=4'b1111 leaves Flags=4'b0100.
- NGROUPS=2, Flags=0, FlagWriteE=2'b10, ALUFlags=4'b1111, AL -> Flags=4'b1100. Then FlagWriteE=2'b01 -> Flags=4'b1111.
- Push with Flags=4'b0010 and a same-cycle write to 4'b1000 -> snapshot=4'b1000. Two later writes to 4'b0001, then restore -> Flags=4'b1000, CkptCount=0, CkptEmpty=1.
- DEPTH=4: 4 pushes -> CkptFull=1. A 5th push -> count stays 4, CkptErr=1. Push+commit while full -> count 4, the oldest snapshot is replaced in FIFO order.
- Restore with a same-cycle push, commit, and AL flag write of 4'b1111, while the head snapshot is 4'b0110 -> Flags=4'b0110, count=0.
- Commit and restore on an empty FIFO -> no state change, CkptErr=1 (0 with the macro undefined). Reset asserted during a restore -> all reset values.
